// File: rtl/frame_pixel_streamer_pkg.sv
// Shared types and constants for the raster pixel streamer.
// The image-size width is also used by sliding_window_unit.
package frame_pixel_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } fps_state_t;

  localparam int RD_LATENCY  = 1;
  localparam int OUT_LATENCY = 2;
  localparam int IMG_SIZE_W  = 12;

endpackage

// File: rtl/frame_pixel_streamer_if.sv
// Memory read port and pixel stream toward the window unit.
// master = streamer side, slave = memory/consumer side.
interface frame_pixel_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);

  logic                  mem_rd_en_out;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_out;
  logic [DATA_WIDTH-1:0] mem_rd_data_in;
  logic [DATA_WIDTH-1:0] fu_pixel_out;
  logic                  fu_pixel_valid_out;
  logic                  fu_row_last_out;
  logic                  fu_frame_last_out;

  modport master (
    output mem_rd_en_out,
    output mem_rd_addr_out,
    input  mem_rd_data_in,
    output fu_pixel_out,
    output fu_pixel_valid_out,
    output fu_row_last_out,
    output fu_frame_last_out
  );

  modport slave (
    input  mem_rd_en_out,
    input  mem_rd_addr_out,
    output mem_rd_data_in,
    input  fu_pixel_out,
    input  fu_pixel_valid_out,
    input  fu_row_last_out,
    input  fu_frame_last_out
  );

endinterface

// File: rtl/frame_pixel_streamer_raster_counter.sv
// Column/row counters and linear read pointer for raster order.
// Flags describe the read being issued in the current cycle.
module raster_counter #(
  parameter int CW         = 6,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [CW-1:0]         size,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic                  row_last,
  output logic                  frame_last
);

  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic [CW-1:0] last;

  assign last       = size - CW'(1);
  assign row_last   = (x == last);
  assign frame_last = row_last && (y == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      ptr <= '0;
    end else if (clear) begin
      x   <= '0;
      y   <= '0;
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr + 1'b1;
      if (row_last) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_pixel_streamer.sv
// Raster-order pixel source: reads an NxN frame from sync memory
// and streams it to the window unit with row/frame markers.
module frame_pixel_streamer
  import frame_pixel_streamer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 16,
  parameter int MAX_IMG_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fu_start_in,
  input  logic [IMG_SIZE_W-1:0] fu_img_size_in,
  input  logic [ADDR_WIDTH-1:0] fu_base_addr_in,
  input  logic                  fu_hold_in,
  output logic                  fu_busy_out,
  output logic                  fu_done_out,
  frame_pixel_streamer_if.master bus
);

  localparam int CW = $clog2(MAX_IMG_WIDTH + 1);

  fps_state_t            state;
  logic [CW-1:0]         size_c;
  logic [CW-1:0]         size_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  drain;
  logic                  busy_q;
  logic                  done_q;
  logic                  rd_en;
  logic                  start_ok;
  logic                  row_last;
  logic                  frame_last;
  logic                  tag_q;
  logic                  row_q;
  logic                  frame_q;
  logic [DATA_WIDTH-1:0] pix_q;
  logic                  valid_q;
  logic                  rl_q;
  logic                  fl_q;

  always_comb begin
    size_c = CW'(fu_img_size_in);
    if (fu_img_size_in > IMG_SIZE_W'(MAX_IMG_WIDTH))
      size_c = CW'(MAX_IMG_WIDTH);
  end

  // Read strobe is combinational so the first read lands in cycle 1.
  assign start_ok = (state == IDLE) && fu_start_in;
  assign rd_en    = (state == STREAM) && !fu_hold_in;

  raster_counter #(
    .CW         (CW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_raster (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .advance    (rd_en),
    .size       (size_q),
    .ptr        (ptr),
    .row_last   (row_last),
    .frame_last (frame_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      size_q <= '0;
      base_q <= '0;
      drain  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fu_start_in) begin
            size_q <= size_c;
            base_q <= fu_base_addr_in;
            busy_q <= 1'b1;
            if (size_c == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (rd_en && frame_last) begin
            state <= DRAIN;
            drain <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain == 1'(OUT_LATENCY - 1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            drain <= drain + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags follow the read by one cycle, then ride with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= 1'b0;
      row_q   <= 1'b0;
      frame_q <= 1'b0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      rl_q    <= 1'b0;
      fl_q    <= 1'b0;
    end else begin
      tag_q   <= rd_en;
      row_q   <= rd_en && row_last;
      frame_q <= rd_en && frame_last;
      valid_q <= tag_q;
      rl_q    <= row_q;
      fl_q    <= frame_q;
      if (tag_q)
        pix_q <= bus.mem_rd_data_in;
    end
  end

  assign bus.mem_rd_en_out      = rd_en;
  assign bus.mem_rd_addr_out    = base_q + ptr;
  assign bus.fu_pixel_out       = pix_q;
  assign bus.fu_pixel_valid_out = valid_q;
  assign bus.fu_row_last_out    = rl_q;
  assign bus.fu_frame_last_out  = fl_q;
  assign fu_busy_out            = busy_q;
  assign fu_done_out            = done_q;

endmodule

// File: doc/frame_pixel_streamer.md
# frame_pixel_streamer

Raster-order pixel source for the sliding-window path. On a start pulse it reads an N×N image from a synchronous on-chip memory and drives `fu_pixel_in` / `fu_pixel_valid_in` of `sliding_window_unit` one pixel per cycle, row by row. It also emits row and frame markers and a completion pulse. It is the transmitter for the window unit's pixel receive port and replaces the bench-side frame task in system builds.

## Interface
- `DATA_WIDTH`, default 8: pixel width.
- `ADDR_WIDTH`, default 16: memory word-address width.
- `MAX_IMG_WIDTH`, default 32: largest supported N. Larger requests are clamped to this value.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `fu_start_in`, in, 1: start pulse. Accepted only in IDLE.
- `fu_img_size_in`, in, 12: image side N. Latched at start.
- `fu_base_addr_in`, in, `ADDR_WIDTH`: address of pixel (0,0). Latched at start.
- `fu_hold_in`, in, 1: while high, no new read is issued.
- `mem_rd_en_out`, out, 1: memory read strobe.
- `mem_rd_addr_out`, out, `ADDR_WIDTH`: read address.
- `mem_rd_data_in`, in, `DATA_WIDTH`: read data, valid in the cycle after `mem_rd_en_out`.
- `fu_pixel_out`, out, `DATA_WIDTH`: pixel to the window unit.
- `fu_pixel_valid_out`, out, 1: pixel qualifier.
- `fu_row_last_out`, out, 1: high with the last valid pixel of each row.
- `fu_frame_last_out`, out, 1: high with the final valid pixel of the frame.
- `fu_busy_out`, out, 1: high in any state other than IDLE.
- `fu_done_out`, out, 1: one-cycle completion pulse.

## Operation
- States and transitions:
  - IDLE → STREAM when `fu_start_in` is sampled high and clamped N > 0.
  - IDLE → DONE when `fu_start_in` is sampled high and N = 0.
  - STREAM → DRAIN after the N²-th read is issued.
  - DRAIN → DONE after 2 cycles.
  - DONE → IDLE after 1 cycle.
- Start handling:
  - At start: latch N' = min(N, `MAX_IMG_WIDTH`) and latch the base address.
  - Clear column counter x, row counter y and the address pointer.
- STREAM behaviour:
  - Each cycle with `fu_hold_in` = 0, assert `mem_rd_en_out` with address = base + pointer.
  - After each issued read: pointer++, x++; when x = N'−1, set x to 0 and y++.
  - Addresses come from a running pointer, not a multiplier. Sums wrap modulo 2^`ADDR_WIDTH`.
- Return pipeline: a 1-cycle-delayed copy of rd_en/row_last/frame_last tags the returning data. The data is registered onto `fu_pixel_out` along with those tags.
- `fu_hold_in` has no effect on reads already issued; in-flight data is always delivered, including during DRAIN.
- `fu_start_in` is ignored while busy, including in DONE.
- `fu_done_out` is high exactly in the DONE cycle.

## Timing
- Start sampled at edge E0: the first `mem_rd_en_out` is high in cycle 1 (after E0).
- Latency from a read strobe to `fu_pixel_valid_out` is 2 cycles. The first valid pixel appears in cycle 3.
- Throughput with hold low: 1 pixel per cycle, no gaps between rows.
- `fu_done_out` asserts the cycle after `fu_frame_last_out`.
- For N = 0, done asserts in cycle 1 after E0 and no read is issued.
- Reset values: every output is 0, and the state is IDLE.
- An asynchronous reset mid-frame aborts immediately:
  - In-flight data is discarded.
  - No done pulse is generated.
  - No partial markers are generated.
- `fu_pixel_out` holds its last value while valid is low. Consumers must qualify it with valid.
- Counters are $clog2(`MAX_IMG_WIDTH`+1) bits wide.

## Structure
- The shared package holds:
  - the state enum (IDLE, STREAM, DRAIN, DONE);
  - `RD_LATENCY` = 1;
  - `OUT_LATENCY` = 2;
  - the `fu_img_size_in` width constant (12), shared with `sliding_window_unit`.
- One sub-module: `raster_counter`. It holds the x/y counters, the pointer, and the row_last/frame_last flag generation, with an advance enable.
- The FSM and the return pipeline stay in the top module.

## Test plan
- **Basic frame:** N=4, base 0x0010, mem[a]=a[7:0], hold low → 16 consecutive valids with pixels 0x10..0x1F, first valid in cycle 3. `fu_row_last_out` on pixels 0x13/0x17/0x1B/0x1F, `fu_frame_last_out` on 0x1F, done on the next cycle.
- **Hold:** N=3, hold high for 3 cycles after the 4th read → exactly 9 valids in order 0..8. One 3-cycle valid gap after the 4th pixel, and no duplicate or lost pixels.
- **Zero size:** N=0 → `mem_rd_en_out` never high, done in cycle 1, busy high for one cycle.
- **Wrap and clamp:**
  - base 0xFFFE, N=2 → addresses FFFE, FFFF, 0000, 0001.
  - N=40 with `MAX_IMG_WIDTH`=32 → 1024 valids.
- **Start while busy:** a start pulse mid-frame is ignored, and the pixel count and sequence are unchanged.
- **Reset mid-frame:** `rst_n` low at pixel 5 of N=4 → all outputs 0 immediately and no done pulse. A new start after release produces a full correct frame.
